vtl_scandoubler: RTL and testbench

Line-doubling video stage placed directly downstream of the VTL chip's RGB/sync output and upstream of the OSD. Each incoming 15 kHz scanline is stored in one half of a ping-pong line buffer and replayed twice at double rate from the other half, producing a ~31 kHz signal with separate HS/VS. Optional scanline attenuation darkens every second output line.

---
 rtl/vtl_scandoubler.sv | 214 +++++++++++++++++++++
 tb/tb_vtl_scandoubler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtl_scandoubler.sv
// ---------------------------------------------------------------------------
// vtl_scandoubler
//
// Line doubler for the VTL chip's 15 kHz RGB output. Each incoming scanline
// is captured into one half of a ping-pong line buffer while the previously
// captured line is replayed twice, at the full F14M rate, from the other half.
// This yields a ~31 kHz picture with a regenerated HS and a VS that only
// changes on input line boundaries.
//
// Optional feature macro: VTL_SCANDOUBLER_SCANLINES_EN
//   defined   - the second replay of every line is dimmed according to
//               'scanlines'
//   undefined - 'scanlines' is ignored; both replays are identical
//
// Ports
//   F14M        system clock (~14.7 MHz)
//   RESET_n     synchronous, active-low reset
//   ce_pix      input pixel enable; all input sampling is qualified by it
//   hs_in/vs_in input syncs, active low
//   r_in/g_in/b_in  6-bit input colour
//   scanlines   00 none, 01 25 %, 10 50 %, 11 75 % dimming of odd lines
//   hs_out      doubled HS, active low
//   vs_out      VS latched at input line starts, active low
//   r_out/g_out/b_out  6-bit output colour, blanked during HS
// ---------------------------------------------------------------------------
module vtl_scandoubler #(
    parameter int LINE_MAX = 512,
    parameter int AW       = 9
) (
    input  logic       F14M,
    input  logic       RESET_n,
    input  logic       ce_pix,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    input  logic [1:0] scanlines,
    output logic       hs_out,
    output logic       vs_out,
    output logic [5:0] r_out,
    output logic [5:0] g_out,
    output logic [5:0] b_out
);

    typedef logic [AW:0] cnt_t;

    localparam cnt_t LINE_FULL = cnt_t'(LINE_MAX);
    localparam cnt_t CNT_SAT   = '1;

    // Input-side state
    logic        hsPrev_q,   hsPrev_d;
    cnt_t        hcntIn_q,   hcntIn_d;
    cnt_t        hsLowCnt_q, hsLowCnt_d;
    cnt_t        lineLen_q,  lineLen_d;
    cnt_t        hsLen_q,    hsLen_d;
    logic        wb_q,       wb_d;
    logic        vsLat_q,    vsLat_d;
    logic [1:0]  valid_q,    valid_d;

    // Output-side state
    logic [AW-1:0] hcntOut_q, hcntOut_d;
    logic          odd_q,     odd_d;

    // Read pipeline stage 1 (aligned with the registered RAM data)
    logic        hs1_q,    hs1_d;
    logic        vs1_q,    vs1_d;
    logic        blank1_q, blank1_d;
    logic        odd1_q,   odd1_d;
    logic [17:0] ramData_q;
    logic [17:0] rgbView;

    logic [17:0] lineBuf [0:2*LINE_MAX-1];

    logic        hsFall;
    logic        writeEn;
    logic        hsActive;
    logic [AW:0] wrAddr;
    logic [AW:0] rdAddr;

    assign hsFall   = ce_pix & hsPrev_q & ~hs_in;
    assign writeEn  = RESET_n & ce_pix & ~hsFall & (hcntIn_q != LINE_FULL);
    assign wrAddr   = {wb_q, hcntIn_q[AW-1:0]};
    assign rdAddr   = {~wb_q, hcntOut_q};
    assign hsActive = ({1'b0, hcntOut_q} < hsLen_q);

    // Next-state logic. The input HS falling edge closes the captured line,
    // swaps buffer halves and restarts the replay of the line just captured.
    // hsLowCnt starts at 1 on the edge because the edge sample itself is the
    // first low sample of the new pulse.
    always_comb begin
        hsPrev_d   = hsPrev_q;
        hcntIn_d   = hcntIn_q;
        hsLowCnt_d = hsLowCnt_q;
        lineLen_d  = lineLen_q;
        hsLen_d    = hsLen_q;
        wb_d       = wb_q;
        vsLat_d    = vsLat_q;
        valid_d    = valid_q;
        hcntOut_d  = hcntOut_q;
        odd_d      = odd_q;

        if (ce_pix) begin
            hsPrev_d = hs_in;
            if (hsFall) begin
                lineLen_d  = hcntIn_q;
                hsLen_d    = hsLowCnt_q;
                hsLowCnt_d = cnt_t'(1);
                hcntIn_d   = '0;
                wb_d       = ~wb_q;
                vsLat_d    = vs_in;
                valid_d    = (valid_q == 2'd2) ? 2'd2 : valid_q + 2'd1;
            end else begin
                if (hcntIn_q != LINE_FULL) begin
                    hcntIn_d = hcntIn_q + cnt_t'(1);
                end
                if (!hs_in && hsLowCnt_q != CNT_SAT) begin
                    hsLowCnt_d = hsLowCnt_q + cnt_t'(1);
                end
            end
        end

        // Replay counter: first wrap marks the second (odd) replay; later
        // wraps keep odd set until the next input line resynchronises.
        if (hsFall) begin
            hcntOut_d = '0;
            odd_d     = 1'b0;
        end else if (lineLen_q != '0 && {1'b0, hcntOut_q} == lineLen_q - cnt_t'(1)) begin
            hcntOut_d = '0;
            odd_d     = 1'b1;
        end else begin
            hcntOut_d = hcntOut_q + AW'(1);
        end

        hs1_d    = ~hsActive;
        blank1_d = hsActive | (valid_q != 2'd2);
        vs1_d    = vsLat_q;
        odd1_d   = odd_q;
    end

`ifdef VTL_SCANDOUBLER_SCANLINES_EN
    function automatic logic [5:0] dimComp(input logic [5:0] x, input logic [1:0] mode);
        case (mode)
            2'b01:   dimComp = x - (x >> 2);
            2'b10:   dimComp = x >> 1;
            2'b11:   dimComp = x >> 2;
            default: dimComp = x;
        endcase
    endfunction

    assign rgbView = odd1_q ? {dimComp(ramData_q[17:12], scanlines),
                               dimComp(ramData_q[11:6],  scanlines),
                               dimComp(ramData_q[5:0],   scanlines)}
                            : ramData_q;
`else
    logic unusedCfg;
    assign unusedCfg = ^{scanlines, odd1_q};
    assign rgbView   = ramData_q;
`endif

    // All control state plus the two output pipeline stages. Stage 2 is the
    // registered output: blanking and dimming applied to the RAM data.
    always_ff @(posedge F14M) begin
        if (!RESET_n) begin
            hsPrev_q   <= 1'b1;
            hcntIn_q   <= '0;
            hsLowCnt_q <= '0;
            lineLen_q  <= '0;
            hsLen_q    <= '0;
            wb_q       <= 1'b0;
            vsLat_q    <= 1'b1;
            valid_q    <= 2'd0;
            hcntOut_q  <= '0;
            odd_q      <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            blank1_q   <= 1'b1;
            odd1_q     <= 1'b0;
            hs_out     <= 1'b1;
            vs_out     <= 1'b1;
            r_out      <= '0;
            g_out      <= '0;
            b_out      <= '0;
        end else begin
            hsPrev_q   <= hsPrev_d;
            hcntIn_q   <= hcntIn_d;
            hsLowCnt_q <= hsLowCnt_d;
            lineLen_q  <= lineLen_d;
            hsLen_q    <= hsLen_d;
            wb_q       <= wb_d;
            vsLat_q    <= vsLat_d;
            valid_q    <= valid_d;
            hcntOut_q  <= hcntOut_d;
            odd_q      <= odd_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            blank1_q   <= blank1_d;
            odd1_q     <= odd1_d;
            hs_out     <= hs1_q;
            vs_out     <= vs1_q;
            {r_out, g_out, b_out} <= blank1_q ? 18'd0 : rgbView;
        end
    end

    // Ping-pong line buffer: write half wb, read the other half. Contents
    // are deliberately not reset; blanking hides stale data after reset.
    always_ff @(posedge F14M) begin
        if (writeEn) begin
            lineBuf[wrAddr] <= {r_in, g_in, b_in};
        end
        ramData_q <= lineBuf[rdAddr];
    end

endmodule

// File: tb/tb_vtl_scandoubler.sv
// ---------------------------------------------------------------------------
// tb_vtl_scandoubler
//
// Self-checking bench for vtl_scandoubler. A line-level model (captured line
// arrays, cycles-since-HS position) predicts every output cycle; directed
// lines with hand-computed expectations pin the model at chosen points.
// Honours VTL_SCANDOUBLER_SCANLINES_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_vtl_scandoubler;

    logic       F14M = 1'b0;
    logic       RESET_n;
    logic       ce_pix;
    logic       hs_in;
    logic       vs_in;
    logic [5:0] r_in;
    logic [5:0] g_in;
    logic [5:0] b_in;
    logic [1:0] scanlines;
    logic       hs_out;
    logic       vs_out;
    logic [5:0] r_out;
    logic [5:0] g_out;
    logic [5:0] b_out;

    vtl_scandoubler #(.LINE_MAX(512), .AW(9)) dut (
        .F14M      (F14M),
        .RESET_n   (RESET_n),
        .ce_pix    (ce_pix),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .scanlines (scanlines),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out)
    );

    always #5 F14M = ~F14M;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rstCyc = 0;
    logic [19:0] hist [0:65535];

    // Model state: the line being captured, the line being replayed, and
    // where in the replay we are (cycles since the last input HS edge).
    logic [17:0] mCurLine  [0:511];
    logic [17:0] mPrevLine [0:511];
    int   mCurCount, mPrevLen, mLowCnt, mHsLen, mValid, mK;
    logic mHsPrev, mVs;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        blank;
        logic        odd;
        logic [17:0] pix;
    } stage_t;

    stage_t st1, outE, rstStage;

    function automatic logic [5:0] dimC(input logic [5:0] x, input logic [1:0] m);
        int xi;
        xi = int'(x);
`ifdef VTL_SCANDOUBLER_SCANLINES_EN
        case (m)
            2'd1:    return 6'(xi - xi / 4);
            2'd2:    return 6'(xi / 2);
            2'd3:    return 6'(xi / 4);
            default: return x;
        endcase
`else
        if (m == 2'd0) return x;
        return 6'(xi);
`endif
    endfunction

    function automatic logic [19:0] pk(input logic h, input logic v, input logic [5:0] c);
        return {h, v, c, c, c};
    endfunction

    function automatic logic [17:0] pixVal(input int kind, input int n);
        logic [5:0] c;
        case (kind)
            0:       c = 6'(n % 64);
            1:       c = 6'h3F;
            default: c = (n < 512) ? 6'(n % 63) : 6'h3F;
        endcase
        return {c, c, c};
    endfunction

    // Model update and per-cycle comparison of every DUT output.
    always begin
        int pos;
        logic fall;
        logic [17:0] expRgb;
        logic [19:0] expV, act;
        @(posedge F14M);
        cyc++;
        rstStage = '{hs: 1'b1, vs: 1'b1, blank: 1'b1, odd: 1'b0, pix: 18'd0};
        if (!RESET_n) begin
            mHsPrev = 1'b1; mCurCount = 0; mPrevLen = 0; mLowCnt = 0;
            mHsLen = 0; mValid = 0; mVs = 1'b1; mK = 0;
            outE = rstStage;
            st1  = rstStage;
        end else begin
            outE = st1;
            pos = (mPrevLen == 0) ? (mK % 512) : (mK % mPrevLen);
            st1.odd   = (mPrevLen != 0) && (mK >= mPrevLen);
            st1.hs    = !(pos < mHsLen);
            st1.blank = (pos < mHsLen) || (mValid < 2);
            st1.vs    = mVs;
            st1.pix   = mPrevLine[pos];
            fall = ce_pix && mHsPrev && !hs_in;
            if (fall) mK = 0; else mK++;
            if (ce_pix) begin
                mHsPrev = hs_in;
                if (fall) begin
                    for (int i = 0; i < 512; i++) mPrevLine[i] = mCurLine[i];
                    mPrevLen  = mCurCount;
                    mHsLen    = mLowCnt;
                    mLowCnt   = 1;
                    mCurCount = 0;
                    mVs       = vs_in;
                    if (mValid < 2) mValid++;
                end else begin
                    if (mCurCount < 512) begin
                        mCurLine[mCurCount] = {r_in, g_in, b_in};
                        mCurCount++;
                    end
                    if (!hs_in && mLowCnt < 1023) mLowCnt++;
                end
            end
        end
        #1;
        if (outE.blank) expRgb = 18'd0;
        else if (outE.odd) expRgb = {dimC(outE.pix[17:12], scanlines),
                                     dimC(outE.pix[11:6],  scanlines),
                                     dimC(outE.pix[5:0],   scanlines)};
        else expRgb = outE.pix;
        expV = {outE.hs, outE.vs, expRgb};
        act  = {hs_out, vs_out, r_out, g_out, b_out};
        if (cyc < 65536) hist[cyc] = act;
        total++;
        if (act !== expV) begin
            bad++;
            $display("[TB] FAIL cycle-compare cyc=%0d actual=%h expected=%h", cyc, act, expV);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int idx, input logic [19:0] expV);
        total++;
        if (idx > cyc || idx < 1 || idx > 65535) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d not recorded (now %0d)", name, idx, cyc);
        end else if (hist[idx] !== expV) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", name, idx, hist[idx], expV);
        end
    endtask

    // Drive one clock cycle of inputs (from a negedge) and wait for the next.
    task automatic applyStimulus(input logic ce, input logic h, input logic v, input logic [17:0] px);
        ce_pix = ce;
        hs_in  = h;
        vs_in  = v;
        {r_in, g_in, b_in} = px;
        @(negedge F14M);
    endtask

    task automatic doReset(input int n, input logic v);
        RESET_n = 1'b0;
        rstCyc  = cyc + 1;
        repeat (n) applyStimulus(1'b0, 1'b1, v, 18'd0);
        RESET_n = 1'b1;
    endtask

    // One input line: an HS edge sample followed by P pixels, ce_pix on
    // every second cycle. edgeCyc is the cycle at which the DUT sees the edge.
    task automatic sendLine(input int P, input int hsLow, input logic vsA, input logic vsB,
                            input int vsAt, input int kind, input int resetAt,
                            output int edgeCyc);
        logic h, v;
        logic [17:0] px;
        edgeCyc = 0;
        for (int s = 0; s <= P; s++) begin
            if (s == resetAt) doReset(3, vsA);
            h  = (s < hsLow) ? 1'b0 : 1'b1;
            v  = (s >= vsAt) ? vsB : vsA;
            px = (s == 0) ? 18'd0 : pixVal(kind, s - 1);
            if (s == 0) edgeCyc = cyc + 1;
            applyStimulus(1'b1, h, v, px);
            applyStimulus(1'b0, h, v, px);
        end
    endtask

    initial begin
        int e, ea, eb, ev1, ev;
        logic [5:0] oddExp [0:2];
        logic [1:0] modes  [0:2];

        RESET_n   = 1'b0;
        scanlines = 2'd0;
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 18'd0);
        checkOutput("reset-c1", 1, pk(1'b1, 1'b1, 6'd0));
        checkOutput("reset-c3", 3, pk(1'b1, 1'b1, 6'd0));
        RESET_n = 1'b1;

        // Nominal ramp lines: 473 pixels, HS low 35 samples.
        e = 0;
        for (int i = 0; i < 4; i++) sendLine(473, 35, 1'b1, 1'b1, 100000, 0, -1, e);
        checkOutput("nom-hs-start",  e + 2,           pk(1'b0, 1'b1, 6'd0));
        checkOutput("nom-hs-last",   e + 2 + 34,      pk(1'b0, 1'b1, 6'd0));
        checkOutput("nom-px35",      e + 2 + 35,      pk(1'b1, 1'b1, 6'd35));
        checkOutput("nom-px100",     e + 2 + 100,     pk(1'b1, 1'b1, 6'd36));
        checkOutput("nom-px472",     e + 2 + 472,     pk(1'b1, 1'b1, 6'd24));
        checkOutput("nom-rep2-hs",   e + 2 + 473,     pk(1'b0, 1'b1, 6'd0));
        checkOutput("nom-rep2-px35", e + 2 + 473 + 35, pk(1'b1, 1'b1, 6'd35));
        checkOutput("nom-rep2-px63", e + 2 + 473 + 63, pk(1'b1, 1'b1, 6'd63));
        checkOutput("nom-rep2-px472", e + 2 + 945,    pk(1'b1, 1'b1, 6'd24));

        // Scanline dimming on constant 3F input.
        modes[0] = 2'd2; modes[1] = 2'd1; modes[2] = 2'd3;
`ifdef VTL_SCANDOUBLER_SCANLINES_EN
        oddExp[0] = 6'h1F; oddExp[1] = 6'h30; oddExp[2] = 6'h0F;
`else
        oddExp[0] = 6'h3F; oddExp[1] = 6'h3F; oddExp[2] = 6'h3F;
`endif
        for (int m = 0; m < 3; m++) begin
            scanlines = modes[m];
            for (int i = 0; i < 3; i++) sendLine(100, 10, 1'b1, 1'b1, 100000, 1, -1, e);
            checkOutput($sformatf("scan%0d-even", modes[m]), e + 2 + 50,  pk(1'b1, 1'b1, 6'h3F));
            checkOutput($sformatf("scan%0d-odd",  modes[m]), e + 2 + 150, pk(1'b1, 1'b1, oddExp[m]));
        end
        scanlines = 2'd0;

        // Over-long lines: 600 pixels, only the first 512 are kept.
        for (int i = 0; i < 3; i++) sendLine(600, 10, 1'b1, 1'b1, 100000, 2, -1, e);
        checkOutput("long-px511",     e + 2 + 511,  pk(1'b1, 1'b1, 6'd7));
        checkOutput("long-wrap-hs",   e + 2 + 512,  pk(1'b0, 1'b1, 6'd0));
        checkOutput("long-rep2-px20", e + 2 + 532,  pk(1'b1, 1'b1, 6'd20));
        checkOutput("long-rep3-px100", e + 2 + 1124, pk(1'b1, 1'b1, 6'd37));

        // Reset mid-line, then two lines to recover.
        sendLine(473, 35, 1'b1, 1'b1, 100000, 0, 200, e);
        checkOutput("midrst-c0", rstCyc,     pk(1'b1, 1'b1, 6'd0));
        checkOutput("midrst-c2", rstCyc + 2, pk(1'b1, 1'b1, 6'd0));
        sendLine(473, 35, 1'b1, 1'b1, 100000, 0, -1, ea);
        sendLine(473, 35, 1'b1, 1'b1, 100000, 0, -1, eb);
        checkOutput("midrst-blank-1st", ea + 2 + 100, pk(1'b1, 1'b1, 6'd0));
        checkOutput("midrst-video-2nd", eb + 2 + 100, pk(1'b1, 1'b1, 6'd36));

        // VS falls mid-line; vs_out must follow only at the next line start.
        sendLine(473, 35, 1'b1, 1'b0, 200, 0, -1, ev1);
        sendLine(473, 35, 1'b0, 1'b0, 100000, 0, -1, ev);
        checkOutput("vs-midline-hold", ev1 + 2 + 418, pk(1'b1, 1'b1, 6'd34));
        checkOutput("vs-before-edge",  ev + 1,        pk(1'b0, 1'b1, 6'd0));
        checkOutput("vs-after-edge",   ev + 2,        pk(1'b0, 1'b0, 6'd0));

        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 18'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
